muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU in the EX stage. It accepts one M-extension operation at a time, sequences a 32-iteration shift-add multiply or restoring divide on operand magnitudes, and applies the sign at the end. It raises a stall request that freezes the front of the pipeline until the result is ready. Divide-by-zero and signed overflow bypass the iterations.

---
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply / restoring divide
// on operand magnitudes, sign applied on completion; div-by-zero and overflow short-circuit.
`timescale 1ns/1ps
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        kill,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  fn_q, fn_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;     // {product} or {remainder, dividend->quotient}
  logic        neg_q, neg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic        a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf, neg_in;
  logic [31:0] abs_a, abs_b, special_res;

  always_comb begin
    a_sgn  = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_sgn  = a_sgn && (funct3 != 3'b010);
    a_neg  = a_sgn && op_a[31];
    b_neg  = b_sgn && op_b[31];
    abs_a  = a_neg ? -op_a : op_a;
    abs_b  = b_neg ? -op_b : op_b;
    is_div = funct3[2];
    // remainder follows the dividend sign; everything else is the product of signs
    neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div0   = is_div && (op_b == '0);
    ovf    = is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == '1);
    if (div0)
      special_res = funct3[1] ? op_a : '1;
    else
      special_res = funct3[1] ? '0 : 32'h8000_0000;
  end

  logic [32:0] mul_sum, div_rem;
  logic [31:0] div_sub, neg_q32, neg_r32;
  logic        div_ge;
  logic [63:0] iter, neg64;
  logic [31:0] fin;

  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_rem = acc_q[63:31];
    div_ge  = div_rem >= {1'b0, opnd_q};
    // difference is always below the divisor, so 32 bits suffice
    div_sub = div_rem[31:0] - opnd_q;
    if (fn_q[2])
      iter = {(div_ge ? div_sub : div_rem[31:0]), acc_q[30:0], div_ge};
    else
      iter = {mul_sum, acc_q[31:1]};
    neg64   = -iter;
    neg_q32 = -iter[31:0];
    neg_r32 = -iter[63:32];
    case (fn_q)
      3'b000:                 fin = neg_q ? neg64[31:0]  : iter[31:0];
      3'b001, 3'b010, 3'b011: fin = neg_q ? neg64[63:32] : iter[63:32];
      3'b100, 3'b101:         fin = neg_q ? neg_q32      : iter[31:0];
      default:                fin = neg_q ? neg_r32      : iter[63:32];
    endcase
  end

  always_comb begin
    state_d = state_q;
    fn_d    = fn_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          fn_d  = funct3;
          neg_d = neg_in;
          cnt_d = '0;
          if (div0 || ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else begin
            opnd_d  = is_div ? abs_b : abs_a;
            acc_d   = {32'd0, (is_div ? abs_a : abs_b)};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = iter;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = fin;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fn_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      fn_q    <= fn_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign stall_req = ((state_q == IDLE) && start && !kill) || (state_q == CALC);
  assign result    = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, kill/reset sequences,
// and random operations compared against a plain-arithmetic RV32M model.
`timescale 1ns/1ps
module tb_muldiv_unit;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, stall_req, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .kill(kill),
    .busy(busy), .stall_req(stall_req), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Called #1 after a rising edge with the unit idle; returns #1 after the edge leaving DONE.
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string nm);
    int lat;
    bit sp;
    sp = is_special(f, a, b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1 chk({nm, " stall_at_accept"}, stall_req, 1);
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      chk({nm, " busy_calc"}, busy, 1);
      chk({nm, " stall_calc"}, stall_req, 1);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, sp ? 0 : 32);
    chk({nm, " result"}, result, exp);
    chk({nm, " stall_done"}, stall_req, 0);
    chk({nm, " busy_done"}, busy, 0);
    @(posedge clk); #1;
    chk({nm, " done_pulse_end"}, done, 0);
    chk({nm, " result_held"}, result, exp);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tv[16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] prior;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    bit          saw_done;

    tv[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3"};
    tv[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"};
    tv[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh_-1x-1"};
    tv[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_-1xmax"};
    tv[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_-7/2"};
    tv[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_-7/2"};
    tv[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        "divu_100/7"};
    tv[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         "remu_100/7"};
    tv[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by0"};
    tv[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         "remu_by0"};
    tv[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
    tv[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf"};
    tv[12] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min2"};
    tv[13] = '{3'd0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "mul_minx-1"};
    tv[14] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         "rem_7/-2"};
    tv[15] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "divu_no_ovf"};

    #3;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset stall", stall_req, 0);
    chk("reset result", result, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tv[i]) run(tv[i].f, tv[i].a, tv[i].b, tv[i].exp, tv[i].nm);

    // kill after ten iterations: no done pulse, result untouched
    prior  = tv[15].exp;
    funct3 = 3'd0; op_a = 32'h1234; op_b = 32'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    #1 chk("kill stall_in_calc", stall_req, 1);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill busy", busy, 0);
    chk("kill done", done, 0);
    chk("kill stall", stall_req, 0);
    chk("kill result", result, prior);
    saw_done = 1'b0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("kill no_done", saw_done, 0);
    chk("kill result_kept", result, prior);
    run(3'd5, 32'd100, 32'd7, 32'd14, "after_kill");

    // start together with kill in IDLE is not accepted
    funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; start = 1'b1; kill = 1'b1;
    #1 chk("startkill stall", stall_req, 0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    chk("startkill busy", busy, 0);
    chk("startkill done", done, 0);

    for (int k = 0; k < 24; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      run(rf, ra, rb, model(rf, ra, rb), "random");
    end

    // asynchronous reset in the middle of an operation
    funct3 = 3'd0; op_a = 32'hDEAD; op_b = 32'hBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset stall", stall_req, 0);
    chk("midreset result", result, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(3'd0, 32'd3, 32'd4, 32'd12, "mul_3x4_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
